// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: FSM states, active-low
// 7-segment patterns ({g,f,e,d,c,b,a}) and the BCD decrement helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Returns {count-1, zero_flag}; zero_flag marks a zero input, which saturates.
  function automatic logic [32:0] bcd_dec(input logic [31:0] count);
    logic [31:0] res;
    logic        borrow;
    res    = count;
    borrow = (count != 32'd0);
    for (int i = 0; i < 8; i++) begin
      if (borrow) begin
        if (res[i*4 +: 4] == 4'd0) begin
          res[i*4 +: 4] = 4'd9;
        end else begin
          res[i*4 +: 4] = res[i*4 +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return {res, (count == 32'd0)};
  endfunction

endpackage

// File: rtl/sseg_scan.sv
// Multiplexed 7-segment driver: free-running scan counter, digit mux,
// BCD decoder and active-low digit enables with a fixed decimal point.
module sseg_scan #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_BITS  = 6,
  parameter int DP_POS     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_DIGITS*4-1:0] digits,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);
  import timer_pkg::*;

  localparam int IW  = $clog2(NUM_DIGITS);
  localparam int IW1 = IW + 1;
  localparam int CW  = SCAN_BITS + IW;

  logic [CW-1:0] scan_q;
  logic [IW-1:0] idx;
  logic [IW:0]   idx_ext;
  logic [3:0]    nibble;
  logic          slot_valid;

  always_ff @(posedge clock) begin
    if (!reset) scan_q <= '0;
    else        scan_q <= scan_q + CW'(1);
  end

  assign idx        = scan_q[CW-1 -: IW];
  assign idx_ext    = {1'b0, idx};
  assign slot_valid = (idx_ext < IW1'(NUM_DIGITS));
  assign dp         = (idx_ext == IW1'(DP_POS));

  // Index values past the last digit select nothing, leaving a blank slot.
  always_comb begin
    nibble = 4'd0;
    an     = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_ext == IW1'(i)) begin
        nibble = digits[i*4 +: 4];
        an[i]  = 1'b0;
      end
    end
  end

  always_comb begin
    seg = SEG_BLANK;
    if (slot_valid) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/countdown_timer_scan.sv
// BCD countdown timer with queued miss penalty, pause, sticky expiry flag
// and a multiplexed 7-segment display of the current count.
module countdown_timer_scan #(
  parameter int          NUM_DIGITS  = 8,
  parameter int          TICK_DIV    = 5000,
  parameter logic [31:0] START_VALUE = 32'h0180_0000,
  parameter int          PENALTY     = 10,
  parameter int          DP_POS      = 4,
  parameter int          SCAN_BITS   = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    miss,
  output logic [NUM_DIGITS*4-1:0] timer_out,
  output logic                    running,
  output logic                    game_over,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an
);
  import timer_pkg::*;

  localparam int            W        = NUM_DIGITS * 4;
  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [9:0]    PEN      = 10'(PENALTY);
  localparam logic [W-1:0]  PRELOAD  = START_VALUE[W-1:0];

  state_t        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    pend_q, pend_d;
  logic          go_q, go_d;
  logic [32:0]   dec_res;
  logic          count_zero;
  logic          run_en;
  logic          tick;
  logic          drain;
  logic [9:0]    pend_sum;
  logic          unused_dec;

  assign dec_res    = bcd_dec(32'(count_q));
  assign count_zero = dec_res[0];
  assign unused_dec = ^(dec_res[32:1] >> W);

  assign run_en   = (state_q == RUN) && !pause;
  assign tick     = run_en && (pre_q == PRE_LAST);
  assign drain    = run_en && !tick && (pend_q != 8'd0) && !count_zero;
  assign pend_sum = {2'b00, pend_q} + (miss ? PEN : 10'd0) - {9'd0, drain};

  // A zero count in RUN is held one cycle, then the FSM moves to EXPIRED.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    pre_d   = pre_q;
    pend_d  = pend_q;
    go_d    = go_q;
    if (start) begin
      state_d = RUN;
      count_d = PRELOAD;
      pre_d   = '0;
      pend_d  = '0;
      go_d    = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (count_zero) begin
            state_d = EXPIRED;
            go_d    = 1'b1;
            pend_d  = '0;
          end else begin
            if (run_en) pre_d = tick ? '0 : pre_q + PW'(1);
            if (tick || drain) count_d = dec_res[W:1];
            pend_d = (pend_sum > 10'd255) ? 8'hFF : pend_sum[7:0];
          end
        end
        default: pend_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= PRELOAD;
      pre_q   <= '0;
      pend_q  <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      pre_q   <= pre_d;
      pend_q  <= pend_d;
      go_q    <= go_d;
    end
  end

  assign timer_out = count_q;
  assign running   = run_en;
  assign game_over = go_q;

  sseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_BITS  (SCAN_BITS),
    .DP_POS     (DP_POS)
  ) u_scan (
    .clock  (clock),
    .reset  (reset),
    .digits (count_q),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

endmodule

// File: doc/countdown_timer_scan.md
Name: countdown_timer_scan

Overview:
- Parametrised BCD countdown timer with penalty on miss, pause/run control, sticky expiry flag and a multiplexed active-low 7-segment driver for N digits.
- Successor to the fixed 8-digit game timer. Sits between the game FSM (start/pause/miss) and the board display.
- Exports the BCD count for scoring logic.

Parameters:
- NUM_DIGITS, 8, displayed/counted BCD digits, 2..8
- TICK_DIV, 5000, clocks per count tick, >=2
- START_VALUE, 32'h0180_0000, BCD preload, low NUM_DIGITS*4 bits used
- PENALTY, 10, counts removed per miss, 1..255
- DP_POS, 4, digit index lighting dp, NUM_DIGITS = none
- SCAN_BITS, 6, prescale bits per digit slot in the scan counter

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse: preload START_VALUE, enter RUN, clear game_over
- pause  in  1  level: holds count and prescaler while high in RUN
- miss   in  1  single-cycle pulse, sampled on clock only: queue PENALTY counts
- timer_out  out  NUM_DIGITS*4  current BCD count
- running    out  1  state==RUN && !pause
- game_over  out  1  sticky expiry flag
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp   out  1  active-high decimal point
- an   out  NUM_DIGITS  digit enables, active-low, one-hot-zero

Behaviour:
- Reset (reset==0 at a clock edge):
  - state=IDLE, timer_out=START_VALUE, prescaler=0, pend=0, game_over=0, scan=0.
  - Outputs after reset: an=~1 (digit 0), seg=pattern of digit 0.
- States:
  - IDLE: start -> RUN.
  - RUN: count reaches 0 -> EXPIRED.
  - EXPIRED: start -> RUN.
  - start in any state reloads the count, clears pend and prescaler, and forces RUN. start wins over miss in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 only when running.
  - tick=1 on the cycle where prescaler==TICK_DIV-1; the prescaler wraps to 0.
  - Frozen otherwise.
- Countdown:
  - On tick the count decrements by 1 via BCD borrow chain (digit 0 -> 9, borrow propagates).
  - Never goes below 0.
- Penalty:
  - miss while running or paused in RUN: pend <= min(pend+PENALTY, 255).
  - miss in IDLE or EXPIRED is ignored.
  - Each running cycle with tick==0, pend>0 and count>0: count decrements by 1 and pend decrements by 1. Penalty therefore drains at one count per clock.
  - tick and drain never coincide; tick has priority and drain resumes the next cycle.
  - miss and drain in the same cycle: pend <= min(pend+PENALTY-1, 255).
- Expiry:
  - The cycle after the count becomes 0 (tick or drain): state=EXPIRED, game_over=1, pend=0.
  - game_over holds until reset or start.
  - timer_out holds 0 in EXPIRED.
- Pause: freezes the count and prescaler and blocks drain. miss still queues.
- Scan:
  - Free-running counter of SCAN_BITS+clog2(NUM_DIGITS) bits.
  - The upper bits select the digit index. If the index >= NUM_DIGITS, an=all-1 (blank slot).
  - an, seg and dp are combinational from the scan index and the registered timer_out.
  - dp=1 iff index==DP_POS.
  - Non-BCD nibble: dash pattern 7'b0111111.
- Latency: start -> timer_out=START_VALUE at the next edge. The first tick occurs TICK_DIV running cycles later.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN, EXPIRED}.
  - Segment constants SEG_0..SEG_9, SEG_DASH (active-low).
  - Function bcd_dec(count) -> {count-1, zero_flag}.
- Sub-module sseg_scan: scan counter, digit mux, decoder and an/dp generation. Parametrised by NUM_DIGITS, SCAN_BITS, DP_POS.

Test Plan:
- Common parameters for all scenarios: NUM_DIGITS=4, TICK_DIV=4, START_VALUE=16'h0012, PENALTY=5, SCAN_BITS=2.
- Reset low, then start pulse -> timer_out=0012 next cycle. After 4 running cycles timer_out=0011. After 12 ticks timer_out=0000, then game_over=1 and state EXPIRED.
- Count 0010, tick -> 0009 (BCD borrow). Count 0100, tick -> 0099.
- Count 0012, miss pulse -> timer_out decrements 1 per clock over 5 clocks to 0007, pend=0. Two misses in back-to-back cycles -> total drop of 10.
- Count 0003 plus miss -> drains to 0000 in 3 clocks, pend cleared, game_over=1. A further miss has no effect.
- pause high for 20 cycles in RUN -> timer_out and prescaler unchanged, running=0. A miss during pause drains only after pause falls.
- Scan: an cycles 1110, 1101, 1011, 0111, each held 4 clocks. seg matches the digit. dp=1 only when an=1110 with DP_POS=0. reset low mid-RUN -> IDLE with timer_out=0012 after one edge.
